mem_tx_sequencer: RTL and testbench

//  Streams a block of 32-bit words from a single-port memory out through uart_tx, one byte at a time.

---
 rtl/mem_tx_sequencer_if.sv | 28 ++
 rtl/mem_tx_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mem_tx_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_tx_sequencer_if.sv
// rtl/mem_tx_sequencer_if.sv - command, memory read and uart_tx handshake bundle for mem_tx_sequencer
interface mem_tx_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] word_count;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [31:0]       mem_rdata;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_active;
   logic              tx_done;

   modport master (
      input  start, base_addr, word_count, mem_rdata, tx_active, tx_done,
      output busy, done, err, mem_addr, mem_rd_en, tx_dv, tx_byte
   );

   modport slave (
      output start, base_addr, word_count, mem_rdata, tx_active, tx_done,
      input  busy, done, err, mem_addr, mem_rd_en, tx_dv, tx_byte
   );
endinterface

// File: rtl/mem_tx_sequencer.sv
// rtl/mem_tx_sequencer.sv - streams memory words to uart_tx LSB byte first; TX_CHECKSUM_EN appends an XOR byte
module mem_tx_sequencer #(
   parameter int MEM_SIZE = 512,
   parameter int ADDR_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_tx_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, WAIT_TX, NEXT, FINISH} state_t;

   localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [ADDR_W-1:0] remaining_q, remaining_n;
   logic [1:0]        byte_idx_q, byte_idx_n;
   logic [31:0]       word_q, word_n;
   logic              tx_dv_q, tx_dv_n;
   logic [7:0]        tx_byte_q, tx_byte_n;
   logic              err_q, err_n;
   logic [ADDR_W:0]   range_end;
   logic [7:0]        cur_byte;
   logic              in_csum;

`ifdef TX_CHECKSUM_EN
   logic [7:0] csum_q, csum_n;
   logic       csum_phase_q, csum_phase_n;
   assign in_csum = csum_phase_q;
`else
   assign in_csum = 1'b0;
`endif

   // One extra bit so a range ending past the top of the address space cannot wrap into legality
   assign range_end = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
   assign cur_byte  = word_q[{byte_idx_q, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= '0;
         err_q        <= 1'b0;
`ifdef TX_CHECKSUM_EN
         csum_q       <= '0;
         csum_phase_q <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         addr_q       <= addr_n;
         remaining_q  <= remaining_n;
         byte_idx_q   <= byte_idx_n;
         word_q       <= word_n;
         tx_dv_q      <= tx_dv_n;
         tx_byte_q    <= tx_byte_n;
         err_q        <= err_n;
`ifdef TX_CHECKSUM_EN
         csum_q       <= csum_n;
         csum_phase_q <= csum_phase_n;
`endif
      end
   end

   always_comb begin
      state_n      = state;
      addr_n       = addr_q;
      remaining_n  = remaining_q;
      byte_idx_n   = byte_idx_q;
      word_n       = word_q;
      tx_dv_n      = 1'b0;
      tx_byte_n    = tx_byte_q;
      err_n        = 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_n       = csum_q;
      csum_phase_n = csum_phase_q;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.word_count == '0) begin
`ifdef TX_CHECKSUM_EN
                  csum_n       = '0;
                  csum_phase_n = 1'b1;
                  state_n      = SEND;
`else
                  state_n      = FINISH;
`endif
               end else if (range_end > MEM_LIMIT) begin
                  err_n = 1'b1;
               end else begin
                  addr_n      = bus.base_addr;
                  remaining_n = bus.word_count;
                  byte_idx_n  = '0;
                  state_n     = RD_REQ;
`ifdef TX_CHECKSUM_EN
                  csum_n       = '0;
                  csum_phase_n = 1'b0;
`endif
               end
            end
         end
         RD_REQ:  state_n = RD_WAIT;
         RD_WAIT: begin
            word_n  = bus.mem_rdata;
            state_n = SEND;
         end
         SEND: begin
            if (!bus.tx_active) begin
               tx_dv_n   = 1'b1;
               tx_byte_n = cur_byte;
               state_n   = WAIT_TX;
`ifdef TX_CHECKSUM_EN
               if (csum_phase_q) tx_byte_n = csum_q;
               else              csum_n    = csum_q ^ cur_byte;
`endif
            end
         end
         WAIT_TX: begin
            if (bus.tx_done) begin
               if (in_csum) begin
                  state_n = FINISH;
               end else if (byte_idx_q != 2'd3) begin
                  byte_idx_n = byte_idx_q + 2'd1;
                  state_n    = SEND;
               end else begin
                  state_n = NEXT;
               end
            end
         end
         NEXT: begin
            remaining_n = remaining_q - ONE;
            // The address only advances when another word follows, so it never points past the block
            if (remaining_q == ONE) begin
`ifdef TX_CHECKSUM_EN
               csum_phase_n = 1'b1;
               state_n      = SEND;
`else
               state_n      = FINISH;
`endif
            end else begin
               addr_n     = addr_q + ONE;
               byte_idx_n = '0;
               state_n    = RD_REQ;
            end
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy      = (state != IDLE) && (state != FINISH);
   assign bus.done      = (state == FINISH);
   assign bus.err       = err_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_rd_en = (state == RD_REQ);
   assign bus.tx_dv     = tx_dv_q;
   assign bus.tx_byte   = tx_byte_q;
endmodule

// File: tb/tb_mem_tx_sequencer.sv
// tb/tb_mem_tx_sequencer.sv - vector-table bench for mem_tx_sequencer with memory and uart_tx models
module tb_mem_tx_sequencer;
`ifdef TX_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif

   typedef struct {
      logic [15:0] base;
      logic [15:0] count;
      bit          exp_err;
      int          exp_bytes;
      logic [7:0]  exp_first;
      logic [7:0]  exp_last;
      logic [7:0]  exp_csum;
   } vec_t;

   logic clk;
   logic rst_n;
   mem_tx_sequencer_if #(.ADDR_W(16)) bus();

   mem_tx_sequencer #(.MEM_SIZE(512), .ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [512];
   logic [7:0]  captured [$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt, err_cnt, rd_cnt, dv_active_cnt;
   int          max_addr;
   bit          model_busy, hold;
   int          model_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered-read memory: a strobe seen in one cycle yields data in the next
   initial begin
      logic        en;
      logic [15:0] a;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         en = bus.mem_rd_en;
         a  = bus.mem_addr;
         @(posedge clk);
         #1;
         if (en) bus.mem_rdata = (a < 16'd512) ? mem[a[8:0]] : 32'hDEAD_BEEF;
      end
   end

   // uart_tx stand-in: busy for four cycles after each byte, then a done pulse
   initial begin
      bus.tx_active = 1'b0;
      bus.tx_done   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_done = 1'b0;
         if (bus.tx_dv) begin
            if (bus.tx_active) dv_active_cnt++;
            captured.push_back(bus.tx_byte);
            model_busy = 1'b1;
            model_cnt  = 3;
         end else if (model_busy) begin
            if (model_cnt == 0) begin
               model_busy  = 1'b0;
               bus.tx_done = 1'b1;
            end else begin
               model_cnt--;
            end
         end
         bus.tx_active = model_busy | hold;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.done)      done_cnt++;
         if (bus.err)       err_cnt++;
         if (bus.mem_rd_en) rd_cnt++;
         if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      captured.delete();
      done_cnt = 0;
      err_cnt  = 0;
      rd_cnt   = 0;
      max_addr = 0;
   endtask

   task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = b;
      bus.word_count = c;
      @(negedge clk);
      bus.start      = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int i;
      for (i = 0; i < 4000; i++) begin
         if (done_cnt != 0 || err_cnt != 0) break;
         @(negedge clk);
      end
      check({name, "_terminated"}, (i < 4000) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Returns the number of bytes differing from the stream this block of memory should produce
   function automatic int stream_mismatches(input logic [15:0] b, input logic [15:0] c);
      logic [7:0]  exp_q [$];
      logic [7:0]  x;
      logic [31:0] wd;
      int          n;
      x = '0;
      for (int w = 0; w < int'(c); w++) begin
         wd = mem[int'(b) + w];
         for (int k = 0; k < 4; k++) begin
            exp_q.push_back(wd[8*k +: 8]);
            x = x ^ wd[8*k +: 8];
         end
      end
      if (CSUM_BYTES != 0) exp_q.push_back(x);
      n = (exp_q.size() > captured.size()) ? exp_q.size() - captured.size()
                                           : captured.size() - exp_q.size();
      for (int k = 0; k < exp_q.size() && k < captured.size(); k++)
         if (captured[k] !== exp_q[k]) n++;
      return n;
   endfunction

   vec_t vecs [7];

   initial begin
      int lat;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.word_count = '0;
      hold = 1'b0;
      model_busy = 1'b0;
      dv_active_cnt = 0;
      for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'hA1B2_C3D4;

      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",      {31'd0, bus.busy},      32'd0);
      check("rst_done",      {31'd0, bus.done},      32'd0);
      check("rst_err",       {31'd0, bus.err},       32'd0);
      check("rst_mem_addr",  {16'd0, bus.mem_addr},  32'd0);
      check("rst_mem_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
      check("rst_tx_dv",     {31'd0, bus.tx_dv},     32'd0);
      check("rst_tx_byte",   {24'd0, bus.tx_byte},   32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      vecs[0] = '{16'd0,      16'd1, 1'b0, 4,  8'hD4, 8'hA1, 8'h04};
      vecs[1] = '{16'd510,    16'd2, 1'b0, 8,  8'hFE, 8'hC0, 8'h01};
      vecs[2] = '{16'd511,    16'd2, 1'b1, 0,  8'h00, 8'h00, 8'h00};
      vecs[3] = '{16'd5,      16'd0, 1'b0, 0,  8'h00, 8'h00, 8'h00};
      vecs[4] = '{16'd511,    16'd1, 1'b0, 4,  8'hFF, 8'hC0, 8'hE0};
      vecs[5] = '{16'hFFFF,   16'd2, 1'b1, 0,  8'h00, 8'h00, 8'h00};
      vecs[6] = '{16'd3,      16'd3, 1'b0, 12, 8'h03, 8'hC0, 8'h1C};

      for (int i = 0; i < 7; i++) begin
         string nm;
         int    nbytes;
         nm = $sformatf("v%0d", i);
         nbytes = vecs[i].exp_err ? 0 : vecs[i].exp_bytes + CSUM_BYTES;
         clear_mon();
         pulse_start(vecs[i].base, vecs[i].count);
         wait_end(nm);
         check({nm, "_err"},   err_cnt,  vecs[i].exp_err ? 1 : 0);
         check({nm, "_done"},  done_cnt, vecs[i].exp_err ? 0 : 1);
         check({nm, "_reads"}, rd_cnt,   vecs[i].exp_err ? 0 : int'(vecs[i].count));
         check({nm, "_nbytes"}, captured.size(), nbytes);
         check({nm, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
         check({nm, "_addr_in_range"}, (max_addr < 512) ? 32'd1 : 32'd0, 32'd1);
         if (!vecs[i].exp_err) begin
            check({nm, "_stream"}, stream_mismatches(vecs[i].base, vecs[i].count), 0);
            if (vecs[i].exp_bytes > 0 && captured.size() > 0)
               check({nm, "_first"}, {24'd0, captured[0]}, {24'd0, vecs[i].exp_first});
`ifdef TX_CHECKSUM_EN
            if (captured.size() > 0)
               check({nm, "_csum"}, {24'd0, captured[$]}, {24'd0, vecs[i].exp_csum});
`else
            if (vecs[i].exp_bytes > 0 && captured.size() > 0)
               check({nm, "_last"}, {24'd0, captured[$]}, {24'd0, vecs[i].exp_last});
`endif
         end
      end

      // Start-to-first-byte latency
      clear_mon();
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 16'd0;
      bus.word_count = 16'd1;
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end while (!bus.tx_dv && lat < 20);
      check("first_dv_latency", lat, 4);
      wait_end("lat");

      // Zero-length request
      clear_mon();
      @(negedge clk);
      bus.start = 1'b1;
      bus.word_count = 16'd0;
      lat = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
`ifdef TX_CHECKSUM_EN
      end while (!bus.tx_dv && lat < 20);
      check("zero_count_csum_dv_latency", lat, 2);
`else
      end while (!bus.done && lat < 20);
      check("zero_count_done_latency", lat, 1);
`endif
      wait_end("zero");
      check("zero_count_reads", rd_cnt, 0);

      // uart_tx held busy before the second byte, with a stray start meanwhile
      clear_mon();
      pulse_start(16'd0, 16'd1);
      for (int i = 0; i < 50 && captured.size() < 1; i++) @(negedge clk);
      hold = 1'b1;
      repeat (50) @(negedge clk);
      pulse_start(16'd5, 16'd3);
      repeat (50) @(negedge clk);
      check("hold_bytes_while_active", captured.size(), 1);
      check("hold_busy", {31'd0, bus.busy}, 32'd1);
      hold = 1'b0;
      wait_end("hold");
      check("hold_nbytes", captured.size(), 4 + CSUM_BYTES);
      check("hold_stream", stream_mismatches(16'd0, 16'd1), 0);
      check("hold_reads", rd_cnt, 1);
      check("hold_done", done_cnt, 1);

      // Asynchronous reset during the third byte of the fifth word
      clear_mon();
      pulse_start(16'd0, 16'd8);
      for (int i = 0; i < 2000 && captured.size() < 19; i++) @(negedge clk);
      check("rst_mid_reached", captured.size(), 19);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_busy",  {31'd0, bus.busy},  32'd0);
      check("rst_mid_tx_dv", {31'd0, bus.tx_dv}, 32'd0);
      check("rst_mid_addr",  {16'd0, bus.mem_addr}, 32'd0);
      model_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_mon();
      pulse_start(16'd100, 16'd1);
      wait_end("after_rst");
      check("after_rst_stream", stream_mismatches(16'd100, 16'd1), 0);
      if (captured.size() > 0) check("after_rst_first", {24'd0, captured[0]}, 32'h64);

      check("dv_while_active", dv_active_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
